cordic_cos_pipe: RTL and testbench

Pipelined CORDIC cosine core: takes an IEEE-754 single-precision angle in radians and returns its cosine and the final CORDIC angle accumulator, both as signed Q2.30 fixed point. A float-to-fixed front stage feeds a chain of 24 rotation-mode CORDIC stages. The block sits between the float datapath and the fixed-point consumers of the trig unit, and accepts one sample per cycle.

---
 rtl/cordic_cos_pipe_pkg.sv | 46 ++++
 rtl/cordic_cos_pipe_if.sv | 13 +
 rtl/cordic_cos_pipe_stage.sv | 68 ++++++
 rtl/cordic_cos_pipe.sv | 71 +++++++
 tb/tb_cordic_cos_pipe.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/cordic_cos_pipe_pkg.sv
// Shared constants, atan table and float-to-Q2.30 unpack for the CORDIC cosine pipe.
package cordic_pkg;

  localparam int STAGES = 24;
  localparam int W      = 32;

  // CORDIC gain compensation 1/prod(sqrt(1+2^-2i)) in Q2.30, pre-loaded into x
  localparam logic [W-1:0] K_INIT = 32'h26DD3B80;

  // round(atan(2^-i) * 2^30)
  localparam logic [W-1:0] ATAN_TAB [0:STAGES-1] = '{
    32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
    32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
    32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
    32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
    32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
    32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080
  };

  // IEEE-754 single to signed Q2.30.
  // value*2^30 = {1,mant} * 2^(e-127-23+30), so the mantissa is shifted by e-120:
  // e=127 (1.0) lands the hidden bit on bit 30. e>=128 is |x|>=2 and cannot be
  // represented, so it saturates; zero/denormal flush to 0. Magnitude is
  // truncated before the sign is applied.
  function automatic logic [W-1:0] f32_to_q2_30(input logic [31:0] f);
    logic [7:0]   e;
    logic [W-1:0] mag;
    logic [W-1:0] shf;
    logic [W-1:0] res;
    e   = f[30:23];
    mag = {8'd0, 1'b1, f[22:0]};
    shf = '0;
    res = '0;
    if (e == 8'd0) begin
      res = '0;
    end else if (e >= 8'd128) begin
      res = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      if (e >= 8'd120) shf = mag << (e - 8'd120);
      else             shf = mag >> (8'd120 - e);
      res = f[31] ? (~shf + 32'd1) : shf;
    end
    return res;
  endfunction

endpackage

// File: rtl/cordic_cos_pipe_if.sv
// Sample-in / result-out bundle of the CORDIC cosine pipe (no backpressure).
interface cordic_cos_pipe_if;
  import cordic_pkg::*;

  logic         in_valid;
  logic [W-1:0] angle;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] theta;

  modport master (output in_valid, angle, input out_valid, result, theta);
  modport slave  (input in_valid, angle, output out_valid, result, theta);
endinterface

// File: rtl/cordic_cos_pipe_stage.sv
// One registered rotation-mode CORDIC iteration; z and valid ride along.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int           SHIFT = 0,
  parameter logic [W-1:0] ATAN  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_i,
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic signed [W-1:0] w_i,
  input  logic signed [W-1:0] z_i,
  output logic                vld_o,
  output logic signed [W-1:0] x_o,
  output logic signed [W-1:0] y_o,
  output logic signed [W-1:0] w_o,
  output logic signed [W-1:0] z_o
);

  logic                vld_q;
  logic signed [W-1:0] x_q, y_q, w_q, z_q;
  logic signed [W-1:0] x_d, y_d, w_d;
  logic signed [W-1:0] x_sh, y_sh;

  // rotate toward z: positive step while the accumulated angle is below target
  always_comb begin
    x_sh = x_i >>> SHIFT;
    y_sh = y_i >>> SHIFT;
    x_d  = x_i;
    y_d  = y_i;
    w_d  = w_i;
    if (w_i < z_i) begin
      x_d = x_i - y_sh;
      y_d = y_i + x_sh;
      w_d = w_i + ATAN;
    end else begin
      x_d = x_i + y_sh;
      y_d = y_i - x_sh;
      w_d = w_i - ATAN;
    end
  end

  // stage register; data advances every cycle, bubbles carry don't-care data
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      w_q   <= '0;
      z_q   <= '0;
    end else begin
      vld_q <= vld_i;
      x_q   <= x_d;
      y_q   <= y_d;
      w_q   <= w_d;
      z_q   <= z_i;
    end
  end

  assign vld_o = vld_q;
  assign x_o   = x_q;
  assign y_o   = y_q;
  assign w_o   = w_q;
  assign z_o   = z_q;

endmodule

// File: rtl/cordic_cos_pipe.sv
// Pipelined CORDIC cosine: float unpack stage followed by 24 rotation stages.
module cordic_cos_pipe
  import cordic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  cordic_cos_pipe_if.slave bus
);

  logic         vld_u_q, vld_u_d;
  logic [W-1:0] z_u_q, z_u_d;

  // per-stage boundaries: index 0 feeds stage 0, index STAGES is the final output
  logic [STAGES:0]     vld_pipe;
  logic signed [W-1:0] x_s [0:STAGES];
  logic signed [W-1:0] y_s [0:STAGES];
  logic signed [W-1:0] w_s [0:STAGES];
  logic signed [W-1:0] z_s [0:STAGES];

  // unpack the incoming float into the rotation target
  always_comb begin
    vld_u_d = bus.in_valid;
    z_u_d   = f32_to_q2_30(bus.angle);
  end

  // stage U register; reset drops a sample presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_u_q <= 1'b0;
      z_u_q   <= '0;
    end else begin
      vld_u_q <= vld_u_d;
      z_u_q   <= z_u_d;
    end
  end

  assign vld_pipe[0] = vld_u_q;
  assign x_s[0]      = K_INIT;
  assign y_s[0]      = '0;
  assign w_s[0]      = '0;
  assign z_s[0]      = z_u_q;

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    cordic_stage #(
      .SHIFT (i),
      .ATAN  (ATAN_TAB[i])
    ) u_stg (
      .clk   (clk),
      .rst   (rst),
      .vld_i (vld_pipe[i]),
      .x_i   (x_s[i]),
      .y_i   (y_s[i]),
      .w_i   (w_s[i]),
      .z_i   (z_s[i]),
      .vld_o (vld_pipe[i+1]),
      .x_o   (x_s[i+1]),
      .y_o   (y_s[i+1]),
      .w_o   (w_s[i+1]),
      .z_o   (z_s[i+1])
    );
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.result    = x_s[STAGES];
  assign bus.theta     = w_s[STAGES];

  // last-stage y and z have no consumer
  logic unused_tail;
  assign unused_tail = ^{y_s[STAGES], z_s[STAGES]};

endmodule

// File: tb/tb_cordic_cos_pipe.sv
// Directed + random bench for cordic_cos_pipe against a real-arithmetic cosine model.
module tb_cordic_cos_pipe;
  import cordic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cordic_cos_pipe_if bus ();

  cordic_cos_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  real sum_atan;

  typedef struct {
    bit          vld;
    logic [31:0] ang;
  } exp_t;
  exp_t exp_q[$];

  // magnitude of a normal single as a real
  function automatic real f32_abs(input logic [31:0] a);
    int e;
    e = int'(a[30:23]);
    return (1.0 + real'(a[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
  endfunction

  // reference unpack: trunc(|x|*2^30) with sign, saturate at |x|>=2, flush denormals
  function automatic longint unpack_ref(input logic [31:0] a);
    longint m;
    real    r;
    if (a[30:23] == 8'd0) return 0;
    if (a[30:23] == 8'hFF) return a[31] ? -64'sd2147483648 : 64'sd2147483647;
    r = f32_abs(a);
    if (r >= 2.0) return a[31] ? -64'sd2147483648 : 64'sd2147483647;
    m = longint'($rtoi(r * 1073741824.0));
    return a[31] ? -m : m;
  endfunction

  function automatic logic [31:0] rand_angle();
    logic [31:0] a;
    do begin
      a = {$urandom_range(1, 0) == 1, 8'($urandom_range(127, 100)), 23'($urandom)};
    end while (f32_abs(a) > 1.74);
    return a;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input longint expv);
    longint d;
    d = longint'($signed(obs)) - expv;
    checks++;
    assert (d <= 1024 && d >= -1024) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (+/-0x400)", tag, obs, 32'(expv));
    end
  endtask

  // one clock: drive on negedge, check 1 time unit after posedge
  task automatic step(input bit r, input bit v, input logic [31:0] a);
    exp_t   e, o;
    real    eff;
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.angle    = a;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      for (int i = 0; i < 24; i++) exp_q.push_back('{1'b0, 32'h0});
      check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_eq("rst_result", bus.result, 32'd0);
      check_eq("rst_theta", bus.theta, 32'd0);
    end else begin
      e.vld = v;
      e.ang = a;
      exp_q.push_back(e);
      o = exp_q.pop_front();
      check_eq("out_valid", {31'd0, bus.out_valid}, {31'd0, o.vld});
      if (o.vld) begin
        // the rotation can only reach +/- sum(atan) however far z lies outside
        eff = real'(unpack_ref(o.ang)) / 1073741824.0;
        if (eff > sum_atan)  eff = sum_atan;
        if (eff < -sum_atan) eff = -sum_atan;
        check_near($sformatf("cos(%h)", o.ang), bus.result, longint'($rtoi($cos(eff) * 1073741824.0)));
        check_near($sformatf("theta(%h)", o.ang), bus.theta, longint'($rtoi(eff * 1073741824.0)));
      end
    end
  endtask

  logic [31:0] corner [0:7];

  initial begin
    sum_atan = 0.0;
    for (int i = 0; i < 24; i++) sum_atan += $atan(2.0 ** real'(-i));
    bus.in_valid = 1'b0;
    bus.angle    = '0;

    corner[0] = 32'h0000_0000; corner[1] = 32'h3F80_0000;
    corner[2] = 32'hBF80_0000; corner[3] = 32'h3F00_0000;
    corner[4] = 32'h4080_0000; corner[5] = 32'hC080_0000;
    corner[6] = 32'h0000_0001; corner[7] = 32'h7F80_0000;

    // unpack function against the reference conversion
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("unpack(%h)", corner[i]), f32_to_q2_30(corner[i]), 32'(unpack_ref(corner[i])));
    check_eq("unpack(1.0) literal", f32_to_q2_30(32'h3F80_0000), 32'h4000_0000);
    check_eq("unpack(-1.0) literal", f32_to_q2_30(32'hBF80_0000), 32'hC000_0000);

    // reset state
    repeat (3) step(1'b1, 1'b0, 32'h0);

    // directed: 0, +1, -1, then 0.5 and 1.0 back to back, a gap, unpack corners
    step(1'b0, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h3F80_0000);
    step(1'b0, 1'b1, 32'hBF80_0000);
    step(1'b0, 1'b1, 32'h3F00_0000);
    step(1'b0, 1'b1, 32'h3F80_0000);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h3F00_0000);
    step(1'b0, 1'b1, 32'h4080_0000);
    step(1'b0, 1'b1, 32'hC080_0000);
    step(1'b0, 1'b1, 32'h0000_0001);
    step(1'b0, 1'b1, 32'h7F80_0000);
    repeat (26) step(1'b0, 1'b0, 32'h0);

    // random in-domain angles with random bubbles
    for (int i = 0; i < 80; i++) step(1'b0, $urandom_range(3, 0) != 0, rand_angle());
    repeat (26) step(1'b0, 1'b0, 32'h0);

    // mid-flight reset: 10 samples, idle, reset with a colliding sample, then one new sample
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, rand_angle());
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h3F80_0000);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h3F00_0000);
    repeat (30) step(1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
